// File: rtl/data_mem_responder_if.sv
// Load/store bus between the CPU (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
   parameter int DATA_W = 16
);
   logic [15:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic              memread;
   logic              memwrite;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output addr, wdata, memread, memwrite,
      input  rdata, ready, busy, err
   );

   modport slave (
      input  addr, wdata, memread, memwrite,
      output rdata, ready, busy, err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory target: accepts one load/store, waits WAIT_CYCLES,
// then answers with a one-cycle ready strobe; bad requests answer with err.
module data_mem_responder #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input logic                 clk,
   input logic                 rst,
   data_mem_responder_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              isRead_q, isRead_d;
   logic              isWrite_q, isWrite_d;
   logic              bad_q, bad_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, err_q, busy_q;
   logic              req;
   logic              rangeBad;

   logic [DATA_W-1:0] mem [DEPTH];

   assign req      = bus.memread | bus.memwrite;
   assign rangeBad = |bus.addr[15:ADDR_W+1];

   // Request capture and decode happen in the accepting cycle, so with zero
   // wait states the response can use the freshly captured values directly.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      isRead_d  = isRead_q;
      isWrite_d = isWrite_q;
      bad_d     = bad_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d     = bus.addr[ADDR_W:1];
               wdata_d   = bus.wdata;
               isRead_d  = bus.memread;
               isWrite_d = bus.memwrite;
               bad_d     = bus.addr[0] | rangeBad | (bus.memread & bus.memwrite);
               cnt_d     = 4'(WAIT_CYCLES);
               state_d   = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == RESP && isRead_d && !bad_d) rdata_d = mem[idx_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         wdata_q   <= '0;
         isRead_q  <= 1'b0;
         isWrite_q <= 1'b0;
         bad_q     <= 1'b0;
         rdata_q   <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         isRead_q  <= isRead_d;
         isWrite_q <= isWrite_d;
         bad_q     <= bad_d;
         rdata_q   <= rdata_d;
         ready_q   <= (state_d == RESP);
         err_q     <= (state_d == RESP) & bad_d;
         busy_q    <= (state_d != IDLE);
      end
   end

   // A reset landing on the response cycle must still discard the store.
   always_ff @(posedge clk) begin
      if (!rst && state_q == RESP && isWrite_q && !bad_q) mem[idx_q] <= wdata_q;
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Drives two responders (2 and 0 wait states) with the same bus traffic and
// checks both every cycle against a transaction-level model.
module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, wdata;
   logic        memread, memwrite;

   always #5 clk = ~clk;

   data_mem_responder_if #(.DATA_W(16)) bus0 ();
   data_mem_responder_if #(.DATA_W(16)) bus1 ();

   assign bus0.addr     = addr;
   assign bus0.wdata    = wdata;
   assign bus0.memread  = memread;
   assign bus0.memwrite = memwrite;
   assign bus1.addr     = addr;
   assign bus1.wdata    = wdata;
   assign bus1.memread  = memread;
   assign bus1.memwrite = memwrite;

   data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave));
   data_mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));

   int assertCount = 0;
   int failCount   = 0;
   int edgeNo      = 0;
   int wc [2]      = '{2, 0};

   bit          mActive [2];
   int          mAcc    [2];
   bit          mLd [2], mSt [2], mBad [2];
   logic [7:0]  mIdx [2];
   logic [15:0] mWd  [2];
   logic [15:0] mMem [2][256];
   logic [15:0] expRd [2];
   bit          expRdy [2], expErr [2], expBusy [2];

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction view: accepted at edge a, response visible after edge a+W,
   // store lands at edge a+W+1, next acceptance possible from edge a+W+2.
   task automatic modelEdge();
      edgeNo++;
      for (int i = 0; i < 2; i++) begin
         bit rdy;
         rdy = 1'b0;
         if (rst) begin
            mActive[i] = 1'b0;
            expRd[i]   = 16'h0;
         end else begin
            if (mActive[i] && edgeNo == mAcc[i] + wc[i] + 1) begin
               if (mSt[i] && !mBad[i]) mMem[i][mIdx[i]] = mWd[i];
               mActive[i] = 1'b0;
            end else if (!mActive[i] && (memread || memwrite)) begin
               mActive[i] = 1'b1;
               mAcc[i]    = edgeNo;
               mLd[i]     = memread;
               mSt[i]     = memwrite;
               mBad[i]    = addr[0] || (addr > 16'h01FF) || (memread && memwrite);
               mIdx[i]    = 8'((addr >> 1) & 16'h00FF);
               mWd[i]     = wdata;
            end
            if (mActive[i] && edgeNo == mAcc[i] + wc[i]) begin
               rdy = 1'b1;
               if (mLd[i] && !mBad[i]) expRd[i] = mMem[i][mIdx[i]];
            end
         end
         expRdy[i]  = rdy;
         expErr[i]  = rdy && mBad[i];
         expBusy[i] = mActive[i];
      end
   endtask

   task automatic checkAll();
      checkOutput("w2.ready", 16'(bus0.ready), 16'(expRdy[0]));
      checkOutput("w2.busy",  16'(bus0.busy),  16'(expBusy[0]));
      checkOutput("w2.err",   16'(bus0.err),   16'(expErr[0]));
      checkOutput("w2.rdata", bus0.rdata,      expRd[0]);
      checkOutput("w0.ready", 16'(bus1.ready), 16'(expRdy[1]));
      checkOutput("w0.busy",  16'(bus1.busy),  16'(expBusy[1]));
      checkOutput("w0.err",   16'(bus1.err),   16'(expErr[1]));
      checkOutput("w0.rdata", bus1.rdata,      expRd[1]);
   endtask

   task automatic step();
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll();
   endtask

   // One-cycle request pulse, then observe both responders until they settle.
   task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d,
                                output int lat0, output int lat1, output bit e0, output bit e1,
                                output logic [15:0] r0, output logic [15:0] r1);
      memread = rd; memwrite = wr; addr = a; wdata = d;
      lat0 = 0; lat1 = 0; e0 = 1'b0; e1 = 1'b0; r0 = 16'hxxxx; r1 = 16'hxxxx;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) begin
            memread = 1'b0; memwrite = 1'b0;
         end
         if (bus0.ready === 1'b1 && lat0 == 0) begin
            lat0 = k; e0 = bus0.err; r0 = bus0.rdata;
         end
         if (bus1.ready === 1'b1 && lat1 == 0) begin
            lat1 = k; e1 = bus1.err; r1 = bus1.rdata;
         end
      end
   endtask

   int          l0, l1, cnt0, cnt1, sel;
   bit          e0, e1;
   logic [15:0] r0, r1;

   initial begin
      rst = 1'b1; addr = 16'h0; wdata = 16'h0; memread = 1'b0; memwrite = 1'b0;
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      checkOutput("rst.rdata", bus0.rdata, 16'h0000);
      checkOutput("rst.busy",  16'(bus0.busy), 16'h0);

      for (int k = 0; k < 32; k++)
         applyStimulus(1'b0, 1'b1, 16'(k * 2), 16'($urandom), l0, l1, e0, e1, r0, r1);

      applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, l0, l1, e0, e1, r0, r1);
      checkOutput("st.lat_w2", 16'(l0), 16'd3);
      checkOutput("st.lat_w0", 16'(l1), 16'd1);
      checkOutput("st.err", 16'(e0), 16'h0);
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, l0, l1, e0, e1, r0, r1);
      checkOutput("ld.lat_w2", 16'(l0), 16'd3);
      checkOutput("ld.rdata_w2", r0, 16'hBEEF);
      checkOutput("ld.rdata_w0", r1, 16'hBEEF);

      applyStimulus(1'b0, 1'b1, 16'h0011, 16'hAAAA, l0, l1, e0, e1, r0, r1);
      checkOutput("misal.err_w2", 16'(e0), 16'h1);
      checkOutput("misal.err_w0", 16'(e1), 16'h1);
      applyStimulus(1'b1, 1'b0, 16'h0400, 16'h0, l0, l1, e0, e1, r0, r1);
      checkOutput("range.err", 16'(e0), 16'h1);
      applyStimulus(1'b1, 1'b1, 16'h0010, 16'h5555, l0, l1, e0, e1, r0, r1);
      checkOutput("both.err", 16'(e0), 16'h1);
      applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, l0, l1, e0, e1, r0, r1);
      checkOutput("noWrite.rdata", r0, 16'hBEEF);

      // A store pulse arriving while both responders are mid-transaction.
      applyStimulus(1'b0, 1'b1, 16'h0020, 16'h1111, l0, l1, e0, e1, r0, r1);
      memread = 1'b1; addr = 16'h0040;
      step();
      memread = 1'b0; memwrite = 1'b1; addr = 16'h0020; wdata = 16'hDEAD;
      step();
      cnt0 = int'(bus0.ready);
      memwrite = 1'b0;
      repeat (6) begin
         step();
         cnt0 += int'(bus0.ready);
      end
      checkOutput("wait.readyCount", 16'(cnt0), 16'd1);
      applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0, l0, l1, e0, e1, r0, r1);
      checkOutput("wait.rdata_w2", r0, 16'h1111);
      checkOutput("wait.rdata_w0", r1, 16'h1111);

      // Reset while the store is still pending.
      applyStimulus(1'b0, 1'b1, 16'h0030, 16'h7777, l0, l1, e0, e1, r0, r1);
      memwrite = 1'b1; addr = 16'h0030; wdata = 16'h1234;
      step();
      memwrite = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("rstMid.busy_w2", 16'(bus0.busy), 16'h0);
      checkOutput("rstMid.busy_w0", 16'(bus1.busy), 16'h0);
      cnt0 = 0;
      repeat (6) begin
         step();
         cnt0 += int'(bus0.ready);
      end
      checkOutput("rstMid.readyCount", 16'(cnt0), 16'd0);
      applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, l0, l1, e0, e1, r0, r1);
      checkOutput("rstMid.rdata_w2", r0, 16'h7777);
      checkOutput("rstMid.rdata_w0", r1, 16'h7777);

      // Back-to-back single-cycle loads: zero-wait responder answers each one.
      cnt1 = 0;
      for (int k = 0; k < 4; k++) begin
         memread = 1'b1; addr = 16'(16'h0010 + 16'(k * 2));
         step();
         cnt1 += int'(bus1.ready);
         memread = 1'b0;
         step();
         cnt1 += int'(bus1.ready);
      end
      checkOutput("b2b.readyCount_w0", 16'(cnt1), 16'd4);
      repeat (4) step();

      for (int c = 0; c < 600; c++) begin
         sel = int'($urandom_range(0, 9));
         memread  = (sel >= 4 && sel <= 6) || sel == 9;
         memwrite = (sel >= 7);
         sel = int'($urandom_range(0, 9));
         addr = 16'($urandom_range(0, 31)) << 1;
         if (sel == 8) addr = addr | 16'h0001;
         if (sel == 9) addr = addr | 16'h0200 | (16'($urandom_range(0, 63)) << 10);
         wdata = 16'($urandom);
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0; memread = 1'b0; memwrite = 1'b0;
      repeat (6) step();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the target side of the CPU's load/store interface (address, write data, memread/memwrite strobes).
- Adds a request/ready handshake with configurable wait states, so the CPU can be moved off a zero-latency memory.
- Checks alignment and address range, and reports errors on a dedicated strobe.
- Holds word storage internally; storage is not cleared by reset.

Parameters:
- ADDR_W, 8, word-index width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- addr  input  16  byte address from the CPU ALU result.
- wdata  input  DATA_W  store data (CPU register read port 2).
- memread  input  1  load request strobe.
- memwrite  input  1  store request strobe.
- rdata  output  DATA_W  load data; valid when ready=1 and the accepted op was a read.
- ready  output  1  one-cycle response strobe.
- busy  output  1  high from acceptance until the cycle after ready.
- err  output  1  valid with ready; high if the request was rejected.

Behaviour:
- One clock domain; everything registered on the rising edge of clk; rst sampled synchronously.
- Reset values: state=IDLE, ready=0, err=0, busy=0, rdata=0, wait counter=0, captured op cleared. Memory array is not reset.
- Reset mid-operation: the transaction aborts, a pending store is discarded, and the block is in IDLE on the next cycle with no ready pulse.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Request = memread | memwrite.
  - On a request: capture addr, wdata and op; set busy=1; load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: decrement the counter each cycle; go to RESP on the cycle the counter reaches 1.
- RESP:
  - ready=1 for exactly one cycle.
  - Store: memory written at the captured index in this cycle.
  - Load: rdata = mem[index], registered and presented with ready.
  - Next state IDLE; busy drops the following cycle.
- Latency: request sampled in IDLE at cycle T gives ready at T+WAIT_CYCLES+1.
- Strobes outside IDLE are ignored; no queuing.
- The initiator must deassert strobes in the cycle after ready. A strobe still high in IDLE is accepted as a new request.
- Address decode:
  - Word index = addr[ADDR_W:1].
  - addr[0]=1 is misaligned.
  - Any nonzero bit in addr[15:ADDR_W+1] is out of range.
- Error cases: misaligned, out of range, or memread & memwrite both high at acceptance.
  - The full handshake still runs: ready at normal latency with err=1.
  - No memory write occurs; rdata holds its previous value.
- rdata holds its last loaded value until the next successful load response. Stores and errors do not change it.
- err=0 whenever ready=0.
- Read-after-write to the same index in back-to-back transactions returns the new data; there is no forwarding hazard, since the write completes in RESP before the next acceptance.

Test Plan:
- Reset and idle: assert rst for 2 cycles, then release with no strobes -> ready=0, err=0, busy=0, rdata=0 held for 10 cycles.
- Store then load (WAIT_CYCLES=2):
  - memwrite with addr=0x0010, wdata=0xBEEF, accepted at T -> ready=1, err=0 at T+3.
  - Then memread with addr=0x0010 -> rdata=0xBEEF with ready, 3 cycles after acceptance.
- Zero wait states (WAIT_CYCLES=0): memread at T -> ready at T+1; back-to-back requests, each held one cycle, complete at one per 2 cycles.
- Error cases:
  - addr=0x0011 store -> ready with err=1, and a later load of 0x0010 still returns the old data.
  - addr=0x0400 with ADDR_W=8 -> err=1.
  - memread=memwrite=1 -> err=1, no write.
- Strobe during WAIT: a second memwrite pulse to 0x0020 during WAIT is ignored -> a load of 0x0020 returns the prior contents; only one ready pulse per accepted request.
- Reset mid-store: memwrite 0x0030=0x1234 accepted, rst asserted in WAIT -> no ready pulse; a later load of 0x0030 returns its pre-reset value; busy=0 the cycle after reset.
